// File: rtl/load_store_unit.sv
// Load/store unit: turns one CPU byte/half/word access into a sequence of
// single-byte beats on an 8-bit data memory port, little-endian, with
// sign/zero extension of load results.
//
// Optional build macro LSU_MISALIGN_CHECK_EN: when defined, misaligned half
// and word accesses are rejected with an error response instead of being
// split into wrapping byte beats.
//
// Timing: handshake cycle -> `beats` XFER cycles -> one RESP cycle -> IDLE.
// Rejected requests skip XFER, so resp_valid follows the handshake by one
// cycle and no memory beat is issued.

module load_store_unit #(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,

  // CPU request side
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [1:0]               req_size,
  input  logic                     req_unsigned,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [31:0]              req_wdata,

  // CPU response side
  output logic                     resp_valid,
  output logic                     resp_err,
  output logic [31:0]              resp_rdata,

  // Data memory side (combinational read)
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_a,
  output logic [DATA_WIDTH-1:0]    mem_wd,
  input  logic [DATA_WIDTH-1:0]    mem_rd
);

  typedef enum logic [1:0] {
    StIdle,
    StXfer,
    StResp
  } state_e;

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

  // Architectural state
  state_e                   state_q, state_d;
  logic                     we_q, we_d;
  logic [1:0]               size_q, size_d;
  logic                     uns_q, uns_d;
  logic [ADDRESS_WIDTH-1:0] base_q, base_d;
  logic [31:0]              wdata_q, wdata_d;
  logic [2:0]               beats_q, beats_d;
  logic [1:0]               cnt_q, cnt_d;
  logic [31:0]              buf_q, buf_d;
  logic                     err_q, err_d;

  // Decoded helpers
  logic       handshake;
  logic       req_reject;
  logic       req_misalign;
  logic [2:0] req_beats;
  logic       last_beat;
  logic       in_xfer;
  logic [31:0] load_ext;

  // Alignment check applied at handshake time (build-time option).
  always_comb begin
`ifdef LSU_MISALIGN_CHECK_EN
    req_misalign = ((req_size == SizeHalf) && req_addr[0]) ||
                   ((req_size == SizeWord) && (req_addr[1:0] != 2'b00));
`else
    req_misalign = 1'b0;
`endif
  end

  // Request decode: beat count per size and the reject condition.
  always_comb begin
    unique case (req_size)
      SizeByte: req_beats = 3'd1;
      SizeHalf: req_beats = 3'd2;
      SizeWord: req_beats = 3'd4;
      default:  req_beats = 3'd0;
    endcase
    req_reject = (req_size == 2'b11) || req_misalign;
  end

  assign req_ready = !rst && (state_q == StIdle);
  assign handshake = req_valid && req_ready;
  assign in_xfer   = !rst && (state_q == StXfer);
  assign last_beat = ((3'(cnt_q) + 3'd1) == beats_q);

  // Next-state logic: latch request, step beats, capture load bytes.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    base_d  = base_q;
    wdata_d = wdata_q;
    beats_d = beats_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (handshake) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          base_d  = req_addr;
          wdata_d = req_wdata;
          beats_d = req_beats;
          cnt_d   = 2'd0;
          buf_d   = 32'h0;
          err_d   = req_reject;
          // A rejected request never touches memory.
          state_d = req_reject ? StResp : StXfer;
        end
      end

      StXfer: begin
        // Loads capture the byte returned for this beat at the edge that ends it.
        if (!we_q) begin
          buf_d[{cnt_q, 3'b000} +: DATA_WIDTH] = mem_rd;
        end
        if (last_beat) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end

      StResp: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      base_q  <= '0;
      wdata_q <= 32'h0;
      beats_q <= 3'd0;
      cnt_q   <= 2'd0;
      buf_q   <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      beats_q <= beats_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
    end
  end

  // Extend the assembled load buffer to 32 bits by access size.
  always_comb begin
    unique case (size_q)
      SizeByte: load_ext = uns_q ? {24'h0, buf_q[7:0]}
                                 : {{24{buf_q[7]}}, buf_q[7:0]};
      SizeHalf: load_ext = uns_q ? {16'h0, buf_q[15:0]}
                                 : {{16{buf_q[15]}}, buf_q[15:0]};
      default:  load_ext = buf_q;
    endcase
  end

  // Memory port: active only during XFER, forced quiet by reset.
  always_comb begin
    mem_we = in_xfer && we_q;
    mem_a  = in_xfer ? (base_q + ADDRESS_WIDTH'(cnt_q)) : '0;
    mem_wd = (in_xfer && we_q) ? wdata_q[{cnt_q, 3'b000} +: DATA_WIDTH] : '0;
  end

  // Response port: a single RESP cycle; data only for successful loads.
  always_comb begin
    resp_valid = !rst && (state_q == StResp);
    resp_err   = resp_valid && err_q;
    resp_rdata = (resp_valid && !err_q && !we_q) ? load_ext : 32'h0;
  end

endmodule
